// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
// Round-robin front end that shares one pipelined Booth multiplier between
// NUM_REQ requesters and routes each product back to its owner by ID tag.
module booth_mul_arbiter #(
  parameter int  N       = 12,
  parameter int  NUM_REQ = 4,
  parameter int  MUL_LAT = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 halt_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [NUM_REQ*N-1:0] req_a_i,
  input  logic [NUM_REQ*N-1:0] req_b_i,
  output logic                 mul_valid_o,
  output logic [N-1:0]         mul_a_o,
  output logic [N-1:0]         mul_b_o,
  input  logic                 mul_valid_i,
  input  logic [2*N-1:0]       mul_product_i,
  output logic                 rsp_valid_o,
  output logic [ID_W-1:0]      rsp_id_o,
  output logic [2*N-1:0]       rsp_product_o,
  output logic                 idle_o,
  output logic                 err_o
);

  // Enough range for every slot between accept and response.
  localparam int CNT_W = $clog2(MUL_LAT + 3);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [N-1:0]       grant_a;
  logic [N-1:0]       grant_b;
  logic               accept;
  logic [ID_W-1:0]    issue_id;
  logic [MUL_LAT-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [MUL_LAT];
  logic               last_v;
  logic [ID_W-1:0]    last_id;
  logic               rsp_fire;
  logic [CNT_W-1:0]   count;
  int                 idx;

  // Round-robin search: scan downwards so the candidate closest to ptr wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    grant_a  = '0;
    grant_b  = '0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid_i[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        grant_a    = req_a_i[idx*N +: N];
        grant_b    = req_b_i[idx*N +: N];
      end
    end
  end

  // Grants are suppressed while halted or in reset; nothing else can stall issue.
  assign req_ready_o = (halt_i || rst_i) ? '0 : grant;
  assign accept      = |(req_ready_o & req_valid_i);

  // Issue register: launches the granted operands and advances the pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mul_valid_o <= 1'b0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
      issue_id    <= '0;
      ptr         <= '0;
    end else begin
      mul_valid_o <= accept;
      if (accept) begin
        mul_a_o  <= grant_a;
        mul_b_o  <= grant_b;
        issue_id <= grant_id;
        ptr      <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

  // Tag shift register that travels alongside the multiplier pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_v <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_v[0]  <= mul_valid_o;
      tag_id[0] <= issue_id;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  assign last_v   = tag_v[MUL_LAT-1];
  assign last_id  = tag_id[MUL_LAT-1];
  assign rsp_fire = mul_valid_i & last_v;

  // Response register; any disagreement between tag and result valid is sticky.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o   <= 1'b0;
      rsp_id_o      <= '0;
      rsp_product_o <= '0;
      err_o         <= 1'b0;
    end else begin
      rsp_valid_o <= rsp_fire;
      if (rsp_fire) begin
        rsp_id_o      <= last_id;
        rsp_product_o <= mul_product_i;
      end
      if (mul_valid_i != last_v) begin
        err_o <= 1'b1;
      end
    end
  end

  // In-flight counter: accepts add one, delivered responses remove one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else begin
      case ({accept, rsp_valid_o})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign idle_o = (count == '0);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter
// Directed bench with a behavioural two-stage multiplier in place of the core.
module tb_booth_mul_arbiter;

  localparam int N       = 12;
  localparam int NUM_REQ = 4;
  localparam int MUL_LAT = 2;

  logic                 clk_i;
  logic                 rst_i;
  logic                 halt_i;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ*N-1:0] req_a_i;
  logic [NUM_REQ*N-1:0] req_b_i;
  logic                 mul_valid_o;
  logic [N-1:0]         mul_a_o;
  logic [N-1:0]         mul_b_o;
  logic                 mul_valid_i;
  logic [2*N-1:0]       mul_product_i;
  logic                 rsp_valid_o;
  logic [1:0]           rsp_id_o;
  logic [2*N-1:0]       rsp_product_o;
  logic                 idle_o;
  logic                 err_o;

  logic                 mul_force;
  logic                 mul_drop;
  logic [1:0]           mp_v;
  logic [2*N-1:0]       mp_p [2];

  int tests_run;
  int tests_failed;

  booth_mul_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .halt_i(halt_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_a_i(req_a_i),
    .req_b_i(req_b_i),
    .mul_valid_o(mul_valid_o),
    .mul_a_o(mul_a_o),
    .mul_b_o(mul_b_o),
    .mul_valid_i(mul_valid_i),
    .mul_product_i(mul_product_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_id_o(rsp_id_o),
    .rsp_product_o(rsp_product_o),
    .idle_o(idle_o),
    .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural multiplier core, reset together with the arbiter.
  always @(posedge clk_i) begin
    if (rst_i) begin
      mp_v    <= '0;
      mp_p[0] <= '0;
      mp_p[1] <= '0;
    end else begin
      mp_v[0] <= mul_valid_o;
      mp_p[0] <= (2*N)'(mul_a_o) * (2*N)'(mul_b_o);
      mp_v[1] <= mp_v[0];
      mp_p[1] <= mp_p[0];
    end
  end

  assign mul_valid_i   = (mp_v[1] & ~mul_drop) | mul_force;
  assign mul_product_i = mp_p[1];

  // Time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a_i[id*N +: N] = a;
    req_b_i[id*N +: N] = b;
  endtask

  task automatic pulse_reset();
    rst_i       = 1'b1;
    halt_i      = 1'b0;
    req_valid_i = '0;
    mul_force   = 1'b0;
    mul_drop    = 1'b0;
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    halt_i      = 1'b0;
    mul_force   = 1'b0;
    mul_drop    = 1'b0;
    req_valid_i = 4'b1111;
    req_a_i     = {4{12'h5A5}};
    req_b_i     = {4{12'h3C3}};
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    tests_run++;
    if (req_ready_o !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready_o);
    end
    tests_run++;
    if ({mul_valid_o, mul_a_o, mul_b_o} !== 25'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_issue: got v=%b a=%h b=%h expected all zero", mul_valid_o, mul_a_o, mul_b_o);
    end
    tests_run++;
    if ({rsp_valid_o, rsp_id_o, rsp_product_o} !== 27'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rsp: got v=%b id=%0d p=%h expected all zero", rsp_valid_o, rsp_id_o, rsp_product_o);
    end
    tests_run++;
    if ({idle_o, err_o} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got idle=%b err=%b expected idle=1 err=0", idle_o, err_o);
    end
    next_cycle();
    rst_i       = 1'b0;
    req_valid_i = '0;
    @(negedge clk_i);
    tests_run++;
    if ({mul_valid_o, idle_o} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got mul_valid=%b idle=%b expected 0 1", mul_valid_o, idle_o);
    end
    next_cycle();
  endtask

  task automatic test_single();
    set_req(0, 12'd100, 12'd37);
    for (int c = 0; c <= 5; c++) begin
      req_valid_i = (c == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk_i);
      if (c == 0) begin
        tests_run++;
        if (req_ready_o !== 4'b0001) begin
          tests_failed++;
          $display("[TB] FAIL single_ready: got %b expected 0001", req_ready_o);
        end
      end
      if (c == 1) begin
        tests_run++;
        if ({mul_valid_o, mul_a_o, mul_b_o} !== {1'b1, 12'd100, 12'd37}) begin
          tests_failed++;
          $display("[TB] FAIL single_issue: got v=%b a=%0d b=%0d expected v=1 a=100 b=37", mul_valid_o, mul_a_o, mul_b_o);
        end
      end
      if (c == 2) begin
        tests_run++;
        if ({mul_valid_o, mul_a_o} !== {1'b0, 12'd100}) begin
          tests_failed++;
          $display("[TB] FAIL single_hold: got v=%b a=%0d expected v=0 a=100", mul_valid_o, mul_a_o);
        end
      end
      if (c >= 1 && c <= 4) begin
        tests_run++;
        if (idle_o !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL single_busy c%0d: got idle=%b expected 0", c, idle_o);
        end
      end
      if (c <= 3) begin
        tests_run++;
        if (rsp_valid_o !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL single_early c%0d: got rsp_valid=%b expected 0", c, rsp_valid_o);
        end
      end
      if (c == 4) begin
        tests_run++;
        if ({rsp_valid_o, rsp_id_o, rsp_product_o} !== {1'b1, 2'd0, 24'd3700}) begin
          tests_failed++;
          $display("[TB] FAIL single_rsp: got v=%b id=%0d p=%0d expected v=1 id=0 p=3700", rsp_valid_o, rsp_id_o, rsp_product_o);
        end
      end
      if (c == 5) begin
        tests_run++;
        if ({rsp_valid_o, idle_o} !== 2'b01) begin
          tests_failed++;
          $display("[TB] FAIL single_done: got rsp_valid=%b idle=%b expected 0 1", rsp_valid_o, idle_o);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_pointer_skip();
    logic [3:0]  vld_tab [4];
    logic [3:0]  rdy_tab [4];
    logic [1:0]  id_tab  [4];
    logic [23:0] p_tab   [4];
    vld_tab = '{4'b1001, 4'b0001, 4'b0011, 4'b0001};
    rdy_tab = '{4'b1000, 4'b0001, 4'b0010, 4'b0001};
    id_tab  = '{2'd3, 2'd0, 2'd1, 2'd0};
    p_tab   = '{24'd63, 24'd4000, 24'd2500, 24'd4000};
    set_req(3, 12'd7, 12'd9);
    set_req(0, 12'd1000, 12'd4);
    set_req(1, 12'd50, 12'd50);
    for (int c = 0; c <= 8; c++) begin
      req_valid_i = (c < 4) ? vld_tab[c] : 4'b0000;
      @(negedge clk_i);
      if (c < 4) begin
        tests_run++;
        if (req_ready_o !== rdy_tab[c]) begin
          tests_failed++;
          $display("[TB] FAIL skip_ready c%0d: got %b expected %b", c, req_ready_o, rdy_tab[c]);
        end
      end
      if (c >= 4 && c < 8) begin
        tests_run++;
        if ({rsp_valid_o, rsp_id_o, rsp_product_o} !== {1'b1, id_tab[c-4], p_tab[c-4]}) begin
          tests_failed++;
          $display("[TB] FAIL skip_rsp c%0d: got v=%b id=%0d p=%0d expected v=1 id=%0d p=%0d",
                   c, rsp_valid_o, rsp_id_o, rsp_product_o, id_tab[c-4], p_tab[c-4]);
        end
      end
      if (c == 8) begin
        tests_run++;
        if ({rsp_valid_o, idle_o} !== 2'b01) begin
          tests_failed++;
          $display("[TB] FAIL skip_done: got rsp_valid=%b idle=%b expected 0 1", rsp_valid_o, idle_o);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_fairness();
    logic [23:0] p_tab [4];
    p_tab = '{24'd20000, 24'd20301, 24'd20604, 24'd20909};
    for (int i = 0; i < 4; i++) begin
      set_req(i, 12'(100 + i), 12'(200 + i));
    end
    for (int c = 0; c < 12; c++) begin
      req_valid_i = (c < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk_i);
      tests_run++;
      if (req_ready_o !== ((c < 8) ? (4'b0001 << (c % 4)) : 4'b0000)) begin
        tests_failed++;
        $display("[TB] FAIL fair_ready c%0d: got %b expected %b", c, req_ready_o,
                 (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000);
      end
      if (c >= 1 && c <= 8) begin
        tests_run++;
        if ({mul_valid_o, mul_a_o} !== {1'b1, 12'(100 + (c - 1) % 4)}) begin
          tests_failed++;
          $display("[TB] FAIL fair_issue c%0d: got v=%b a=%0d expected v=1 a=%0d", c, mul_valid_o, mul_a_o, 100 + (c - 1) % 4);
        end
      end
      if (c >= 4) begin
        tests_run++;
        if ({rsp_valid_o, rsp_id_o, rsp_product_o} !== {1'b1, 2'((c - 4) % 4), p_tab[(c - 4) % 4]}) begin
          tests_failed++;
          $display("[TB] FAIL fair_rsp c%0d: got v=%b id=%0d p=%0d expected v=1 id=%0d p=%0d",
                   c, rsp_valid_o, rsp_id_o, rsp_product_o, (c - 4) % 4, p_tab[(c - 4) % 4]);
        end
      end
      next_cycle();
    end
    @(negedge clk_i);
    tests_run++;
    if ({rsp_valid_o, idle_o} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL fair_done: got rsp_valid=%b idle=%b expected 0 1", rsp_valid_o, idle_o);
    end
    next_cycle();
  endtask

  task automatic test_max_operands();
    set_req(2, 12'hFFF, 12'hFFF);
    for (int c = 0; c <= 5; c++) begin
      req_valid_i = (c == 0) ? 4'b0100 : 4'b0000;
      @(negedge clk_i);
      if (c == 0) begin
        tests_run++;
        if (req_ready_o !== 4'b0100) begin
          tests_failed++;
          $display("[TB] FAIL max_ready: got %b expected 0100", req_ready_o);
        end
      end
      if (c == 4) begin
        tests_run++;
        if ({rsp_valid_o, rsp_id_o, rsp_product_o} !== {1'b1, 2'd2, 24'hFFE001}) begin
          tests_failed++;
          $display("[TB] FAIL max_rsp: got v=%b id=%0d p=%h expected v=1 id=2 p=ffe001", rsp_valid_o, rsp_id_o, rsp_product_o);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_halt();
    set_req(0, 12'd3, 12'd5);
    set_req(1, 12'd6, 12'd7);
    set_req(2, 12'd2, 12'd11);
    for (int c = 0; c <= 12; c++) begin
      halt_i = (c >= 2 && c <= 6);
      case (c)
        0:       req_valid_i = 4'b0001;
        1:       req_valid_i = 4'b0010;
        2, 3, 4, 5, 6, 7: req_valid_i = 4'b0100;
        default: req_valid_i = 4'b0000;
      endcase
      @(negedge clk_i);
      if (c == 0 || c == 1 || c == 7) begin
        tests_run++;
        if (req_ready_o !== ((c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0100)) begin
          tests_failed++;
          $display("[TB] FAIL halt_grant c%0d: got %b", c, req_ready_o);
        end
      end
      if (c >= 2 && c <= 6) begin
        tests_run++;
        if (req_ready_o !== 4'b0000) begin
          tests_failed++;
          $display("[TB] FAIL halt_blocked c%0d: got %b expected 0000", c, req_ready_o);
        end
      end
      if (c == 4) begin
        tests_run++;
        if ({rsp_valid_o, rsp_id_o, rsp_product_o} !== {1'b1, 2'd0, 24'd15}) begin
          tests_failed++;
          $display("[TB] FAIL halt_rsp0: got v=%b id=%0d p=%0d expected v=1 id=0 p=15", rsp_valid_o, rsp_id_o, rsp_product_o);
        end
      end
      if (c == 5) begin
        tests_run++;
        if ({rsp_valid_o, rsp_id_o, rsp_product_o, idle_o} !== {1'b1, 2'd1, 24'd42, 1'b0}) begin
          tests_failed++;
          $display("[TB] FAIL halt_rsp1: got v=%b id=%0d p=%0d idle=%b expected v=1 id=1 p=42 idle=0",
                   rsp_valid_o, rsp_id_o, rsp_product_o, idle_o);
        end
      end
      if (c == 6) begin
        tests_run++;
        if ({rsp_valid_o, idle_o} !== 2'b01) begin
          tests_failed++;
          $display("[TB] FAIL halt_idle: got rsp_valid=%b idle=%b expected 0 1", rsp_valid_o, idle_o);
        end
      end
      if (c == 11) begin
        tests_run++;
        if ({rsp_valid_o, rsp_id_o, rsp_product_o} !== {1'b1, 2'd2, 24'd22}) begin
          tests_failed++;
          $display("[TB] FAIL halt_resume_rsp: got v=%b id=%0d p=%0d expected v=1 id=2 p=22", rsp_valid_o, rsp_id_o, rsp_product_o);
        end
      end
      next_cycle();
    end
    halt_i = 1'b0;
  endtask

  task automatic test_reset_mid_flight();
    set_req(0, 12'd11, 12'd11);
    set_req(1, 12'd12, 12'd12);
    set_req(2, 12'd13, 12'd13);
    set_req(3, 12'd14, 12'd14);
    for (int c = 0; c <= 9; c++) begin
      rst_i = (c == 3);
      case (c)
        0:       req_valid_i = 4'b0001;
        1:       req_valid_i = 4'b0010;
        2:       req_valid_i = 4'b0100;
        3:       req_valid_i = 4'b1000;
        default: req_valid_i = 4'b0000;
      endcase
      @(negedge clk_i);
      if (c == 2) begin
        tests_run++;
        if ({req_ready_o, idle_o} !== {4'b0100, 1'b0}) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_busy: got ready=%b idle=%b expected 0100 0", req_ready_o, idle_o);
        end
      end
      if (c == 3) begin
        tests_run++;
        if (req_ready_o !== 4'b0000) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_ready_gated: got %b expected 0000", req_ready_o);
        end
      end
      if (c >= 4) begin
        tests_run++;
        if ({rsp_valid_o, idle_o, err_o, mul_valid_o} !== 4'b0100) begin
          tests_failed++;
          $display("[TB] FAIL rstmid_after c%0d: got rsp_valid=%b idle=%b err=%b mul_valid=%b expected 0 1 0 0",
                   c, rsp_valid_o, idle_o, err_o, mul_valid_o);
        end
      end
      next_cycle();
    end
    rst_i = 1'b0;
  endtask

  task automatic test_spurious();
    for (int c = 0; c <= 3; c++) begin
      mul_force = (c == 0);
      @(negedge clk_i);
      tests_run++;
      if ({err_o, rsp_valid_o} !== {(c != 0), 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL spurious c%0d: got err=%b rsp_valid=%b expected err=%b rsp_valid=0", c, err_o, rsp_valid_o, c != 0);
      end
      next_cycle();
    end
    pulse_reset();
    @(negedge clk_i);
    tests_run++;
    if (err_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL spurious_clear: got err=%b expected 0", err_o);
    end
    next_cycle();
    // A tagged operation whose result never appears.
    set_req(0, 12'd2, 12'd3);
    mul_drop = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      req_valid_i = (c == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk_i);
      if (c == 3) begin
        tests_run++;
        if (err_o !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL drop_early: got err=%b expected 0", err_o);
        end
      end
      if (c >= 4) begin
        tests_run++;
        if ({err_o, rsp_valid_o, idle_o} !== 3'b100) begin
          tests_failed++;
          $display("[TB] FAIL drop_err c%0d: got err=%b rsp_valid=%b idle=%b expected 1 0 0", c, err_o, rsp_valid_o, idle_o);
        end
      end
      next_cycle();
    end
    pulse_reset();
  endtask

  // Run every scenario in order, then report.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_i        = 1'b1;
    halt_i       = 1'b0;
    req_valid_i  = '0;
    req_a_i      = '0;
    req_b_i      = '0;
    mul_force    = 1'b0;
    mul_drop     = 1'b0;
    test_reset();
    test_single();
    test_pointer_skip();
    pulse_reset();
    test_fairness();
    test_max_operands();
    test_halt();
    test_reset_mid_flight();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
